// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-source result-path arbiter.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } arb_state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // One bit wider than MAX_BURST's range so burst+1 never wraps when saturated at 15.
    localparam int BURST_W = 5;

endpackage

// File: rtl/mux2_arb_ctrl_mux2_32.sv
// 32-bit two-input word select used on the shared result path.
module mux2_32
    import mux_arb_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mux2_ctr,
    output logic [31:0] y
);

    assign y = (mux2_ctr == SRC_B) ? b : a;

endmodule

// File: rtl/mux2_arb_ctrl.sv
// Round-robin arbiter with bounded burst lock feeding one registered valid/ready output stage.
module mux2_arb_ctrl
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,
    input  logic              out_ready,
    output logic              mux2_ctr,
    output logic [CNT_W-1:0]  a_cnt,
    output logic [CNT_W-1:0]  b_cnt
);

    localparam logic [BURST_W-1:0] MAX_BURST_L = BURST_W'(MAX_BURST);

    arb_state_t         state_reg, state_next;
    logic               last_reg, last_next;
    logic [BURST_W-1:0] burst_reg, burst_next;
    logic               out_valid_reg;
    logic [DATA_W-1:0]  out_data_reg;
    logic               out_src_reg;

    logic               slot_free, grant_b, cur_valid, other_valid;
    logic               xfer_a, xfer_b, xfer;
    logic [BURST_W-1:0] burst_inc;
    logic               burst_done;
    logic [DATA_W-1:0]  sel_data;

    always_comb begin
        slot_free   = !out_valid_reg || out_ready;
        grant_b     = (state_reg == GNT_B);
        mux2_ctr    = rst_n && grant_b;
        a_ready     = rst_n && (state_reg == GNT_A) && slot_free;
        b_ready     = rst_n && grant_b && slot_free;
        xfer_a      = a_valid && a_ready;
        xfer_b      = b_valid && b_ready;
        xfer        = xfer_a || xfer_b;
        cur_valid   = grant_b ? b_valid : a_valid;
        other_valid = grant_b ? a_valid : b_valid;
        burst_inc   = burst_reg + BURST_W'(1);
        // Once saturated, the very next transfer hands over as soon as the other side asks.
        burst_done  = (burst_inc >= MAX_BURST_L);
    end

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        burst_next = burst_reg;
        case (state_reg)
            IDLE: begin
                if (a_valid && b_valid) begin
                    state_next = (last_reg == SRC_B) ? GNT_A : GNT_B;
                end else if (a_valid) begin
                    state_next = GNT_A;
                end else if (b_valid) begin
                    state_next = GNT_B;
                end
            end
            GNT_A, GNT_B: begin
                if (!cur_valid) begin
                    state_next = IDLE;
                    last_next  = grant_b;
                    burst_next = '0;
                end else if (xfer) begin
                    if (burst_done && other_valid) begin
                        state_next = grant_b ? GNT_A : GNT_B;
                        last_next  = grant_b;
                        burst_next = '0;
                    end else begin
                        burst_next = burst_done ? MAX_BURST_L : burst_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            last_reg  <= SRC_B;
            burst_reg <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            burst_reg <= burst_next;
        end
    end

    generate
        if (DATA_W == 32) begin : g_mux32
            mux2_32 u_mux2_32 (
                .a        (a_data),
                .b        (b_data),
                .mux2_ctr (mux2_ctr),
                .y        (sel_data)
            );
        end else begin : g_mux_generic
            assign sel_data = mux2_ctr ? b_data : a_data;
        end
    endgenerate

    // A push takes priority over a pop so pop+push in one cycle streams back-to-back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= SRC_A;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sel_data;
            out_src_reg   <= xfer_b;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

    logic [1:0]            xfer_vec;
    logic [1:0][CNT_W-1:0] cnt_bus;

    assign xfer_vec = {xfer_b, xfer_a};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (xfer_vec[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign cnt_bus[gi] = cnt_reg;
        end
    endgenerate

    assign a_cnt = cnt_bus[SRC_A];
    assign b_cnt = cnt_bus[SRC_B];

endmodule

// File: tb/tb_mux2_arb_ctrl.sv
// Scenario bench for mux2_arb_ctrl: directed feature tasks plus a randomized queue scoreboard.
module tb_mux2_arb_ctrl;

    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, b_valid, out_ready;
    logic [DATA_W-1:0] a_data, b_data, out_data;
    logic              a_ready, b_ready, out_valid, out_src, mux2_ctr;
    logic [CNT_W-1:0]  a_cnt, b_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [DATA_W-1:0] a_src_q[$], b_src_q[$];
    logic [DATA_W-1:0] exp_a_q[$], exp_b_q[$];
    logic [DATA_W-1:0] out_data_log[$];
    bit                out_src_log[$];
    int                out_cyc_log[$];

    bit                s_a_ready, s_b_ready, s_mux, s_out_valid, s_a_valid, s_b_valid;
    logic [DATA_W-1:0] s_out_data;
    logic [CNT_W-1:0]  s_a_cnt, s_b_cnt;
    bit                a_acc, b_acc, popped;

    always #5 clk = ~clk;

    mux2_arb_ctrl #(
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .mux2_ctr  (mux2_ctr),
        .a_cnt     (a_cnt),
        .b_cnt     (b_cnt)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        a_data = '0; b_data = '0;
        a_src_q.delete(); b_src_q.delete(); exp_a_q.delete(); exp_b_q.delete();
        out_data_log.delete(); out_src_log.delete(); out_cyc_log.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive sources (valid held until accepted), sample at negedge+1, advance.
    task automatic run_cycle(input bit rdy, input bit a_en, input bit b_en);
        a_valid   = (a_src_q.size() > 0) && (a_en || a_valid);
        b_valid   = (b_src_q.size() > 0) && (b_en || b_valid);
        a_data    = a_valid ? a_src_q[0] : '0;
        b_data    = b_valid ? b_src_q[0] : '0;
        out_ready = rdy;
        #1;
        s_a_ready = a_ready; s_b_ready = b_ready; s_mux = mux2_ctr;
        s_out_valid = out_valid; s_out_data = out_data;
        s_a_cnt = a_cnt; s_b_cnt = b_cnt; s_a_valid = a_valid; s_b_valid = b_valid;
        a_acc  = a_valid && a_ready;
        b_acc  = b_valid && b_ready;
        popped = out_valid && out_ready;
        if (popped) begin
            out_data_log.push_back(out_data);
            out_src_log.push_back(out_src);
            out_cyc_log.push_back(cyc);
            $display("cycle %0d: word src=%0d data=%08h", cyc, out_src, out_data);
        end
        if (a_acc) exp_a_q.push_back(a_src_q.pop_front());
        if (b_acc) exp_b_q.push_back(b_src_q.pop_front());
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
        a_data = 32'h11; b_data = 32'h22;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk); #1;
            n_checks++; if (a_ready !== 1'b0) begin n_fails++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
            n_checks++; if (b_ready !== 1'b0) begin n_fails++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
            n_checks++; if (mux2_ctr !== 1'b0) begin n_fails++; $display("FAIL reset_mux2_ctr: got %b want 0", mux2_ctr); end
            n_checks++; if (out_valid !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
            n_checks++; if (out_data !== '0 || out_src !== 1'b0) begin n_fails++; $display("FAIL reset_out_reg: got data=%h src=%b want 0/0", out_data, out_src); end
            n_checks++; if (a_cnt !== '0 || b_cnt !== '0) begin n_fails++; $display("FAIL reset_cnt: got a=%0d b=%0d want 0/0", a_cnt, b_cnt); end
        end
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fails++; $display("FAIL reset_idle_bubble: got a_ready=%b b_ready=%b want 0/0", a_ready, b_ready); end
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0 || mux2_ctr !== 1'b0) begin
            n_fails++; $display("FAIL reset_first_grant: got a_ready=%b b_ready=%b mux=%b want 1/0/0", a_ready, b_ready, mux2_ctr);
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic test_single_source();
        int first_acc = -1, last_acc = -1;
        bit a_seen = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) b_src_q.push_back(32'h100 + i);
        for (int c = 0; c < 40 && out_data_log.size() < 10; c++) begin
            run_cycle(1'b1, 1'b1, 1'b1);
            if (s_a_ready) a_seen = 1;
            if (b_acc) begin
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                n_checks++; if (s_mux !== 1'b1) begin n_fails++; $display("FAIL single_mux2_ctr: got %b want 1", s_mux); end
            end
        end
        #1;
        n_checks++; if (out_data_log.size() != 10) begin n_fails++; $display("FAIL single_count: got %0d words want 10", out_data_log.size()); end
        for (int k = 0; k < out_data_log.size(); k++) begin
            n_checks++;
            if (out_data_log[k] !== 32'h100 + k || out_src_log[k] !== 1'b1) begin
                n_fails++; $display("FAIL single_word%0d: got %h src=%b want %h src=1", k, out_data_log[k], out_src_log[k], 32'h100 + k);
            end
        end
        n_checks++; if (b_cnt !== 4'd10 || a_cnt !== 4'd0) begin n_fails++; $display("FAIL single_cnt: got a=%0d b=%0d want 0/10", a_cnt, b_cnt); end
        n_checks++; if (a_seen) begin n_fails++; $display("FAIL single_no_a_grant: got a_ready=1 want never"); end
        n_checks++; if (last_acc - first_acc != 9) begin n_fails++; $display("FAIL single_grant_held: got span %0d want 9", last_acc - first_acc); end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            a_src_q.push_back(32'hA000 + i);
            b_src_q.push_back(32'hB000 + i);
        end
        for (int c = 0; c < 80 && out_data_log.size() < 24; c++) run_cycle(1'b1, 1'b1, 1'b1);
        n_checks++; if (out_data_log.size() != 24) begin n_fails++; $display("FAIL contention_count: got %0d words want 24", out_data_log.size()); end
        for (int k = 0; k < out_data_log.size(); k++) begin
            bit                exp_src = ((k / MAX_BURST) % 2) == 1;
            logic [DATA_W-1:0] exp_dat = (exp_src ? 32'hB000 : 32'hA000) + (k / (2 * MAX_BURST)) * MAX_BURST + (k % MAX_BURST);
            n_checks++;
            if (out_src_log[k] !== exp_src || out_data_log[k] !== exp_dat) begin
                n_fails++; $display("FAIL contention_word%0d: got src=%b %h want src=%b %h", k, out_src_log[k], out_data_log[k], exp_src, exp_dat);
            end
        end
        if (out_cyc_log.size() == 24) begin
            n_checks++; if (out_cyc_log[23] - out_cyc_log[0] != 23) begin n_fails++; $display("FAIL contention_no_bubble: got span %0d want 23", out_cyc_log[23] - out_cyc_log[0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] held;
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            a_src_q.push_back(32'hA000 + i);
            b_src_q.push_back(32'hB000 + i);
        end
        for (int c = 0; c < 80 && out_data_log.size() < 12; c++) begin
            bit stall = (c >= 3 && c <= 7);
            run_cycle(!stall, 1'b1, 1'b1);
            if (c == 3) held = s_out_data;
            if (stall) begin
                n_checks++;
                if (s_out_data !== 32'hA001 || s_a_ready !== 1'b0 || s_out_valid !== 1'b1) begin
                    n_fails++; $display("FAIL backpressure_stall%0d: got data=%h a_ready=%b valid=%b want A001/0/1", c, s_out_data, s_a_ready, s_out_valid);
                end
                if (c > 3) begin
                    n_checks++; if (s_out_data !== held) begin n_fails++; $display("FAIL backpressure_stable: got %h want %h", s_out_data, held); end
                end
            end
        end
        n_checks++; if (out_data_log.size() != 12) begin n_fails++; $display("FAIL backpressure_count: got %0d words want 12", out_data_log.size()); end
        for (int k = 0; k < out_data_log.size(); k++) begin
            bit                exp_src = ((k / MAX_BURST) % 2) == 1;
            logic [DATA_W-1:0] exp_dat = (exp_src ? 32'hB000 : 32'hA000) + (k / (2 * MAX_BURST)) * MAX_BURST + (k % MAX_BURST);
            n_checks++;
            if (out_src_log[k] !== exp_src || out_data_log[k] !== exp_dat) begin
                n_fails++; $display("FAIL backpressure_word%0d: got src=%b %h want src=%b %h", k, out_src_log[k], out_data_log[k], exp_src, exp_dat);
            end
        end
    endtask

    task automatic test_saturation_reset();
        int n_acc = 0;
        apply_reset();
        for (int i = 0; i < 24; i++) a_src_q.push_back(32'hC000 + i);
        for (int c = 0; c < 60 && n_acc < 20; c++) begin
            run_cycle(1'b1, 1'b1, 1'b0);
            if (a_acc) n_acc++;
        end
        run_cycle(1'b1, 1'b1, 1'b0);
        n_checks++; if (s_a_cnt !== 4'hF) begin n_fails++; $display("FAIL sat_a_cnt: got %h want f (after %0d accepts)", s_a_cnt, n_acc); end
        n_checks++; if (s_out_valid !== 1'b1) begin n_fails++; $display("FAIL sat_pre_reset_valid: got %b want 1", s_out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (a_ready !== 1'b0 || mux2_ctr !== 1'b0) begin n_fails++; $display("FAIL midreset_ready: got a_ready=%b mux=%b want 0/0", a_ready, mux2_ctr); end
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if (out_valid !== 1'b0 || a_cnt !== '0) begin n_fails++; $display("FAIL midreset_state: got valid=%b a_cnt=%0d want 0/0", out_valid, a_cnt); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (a_ready !== 1'b0) begin n_fails++; $display("FAIL midreset_idle: got a_ready=%b want 0", a_ready); end
        @(posedge clk); @(negedge clk); #1;
        n_checks++; if (a_ready !== 1'b1) begin n_fails++; $display("FAIL midreset_regrant: got a_ready=%b want 1", a_ready); end
        a_valid = 1'b0;
    endtask

    task automatic test_random();
        int tot_a = 0, tot_b = 0, a_run = 0, b_run = 0, seq = 0;
        logic [DATA_W-1:0] exp_w;
        apply_reset();
        for (int c = 0; c < 700; c++) begin
            bit drain = (c >= 500);
            if (!drain && a_src_q.size() < 3 && $urandom_range(0, 2) == 0) a_src_q.push_back({$urandom_range(0, 65535), seq[15:0]});
            if (!drain && b_src_q.size() < 3 && $urandom_range(0, 2) == 0) b_src_q.push_back({$urandom_range(0, 65535), seq[15:0]});
            seq++;
            run_cycle(drain || ($urandom_range(0, 3) != 0), drain || ($urandom_range(0, 3) != 0), drain || ($urandom_range(0, 3) != 0));
            n_checks++; if (s_a_ready && s_b_ready) begin n_fails++; $display("FAIL rand_ready_excl: got both ready want at most one"); end
            n_checks++;
            if (s_a_cnt !== CNT_W'(tot_a > 15 ? 15 : tot_a) || s_b_cnt !== CNT_W'(tot_b > 15 ? 15 : tot_b)) begin
                n_fails++; $display("FAIL rand_cnt: got a=%0d b=%0d want %0d/%0d", s_a_cnt, s_b_cnt, tot_a > 15 ? 15 : tot_a, tot_b > 15 ? 15 : tot_b);
            end
            if (a_acc) begin tot_a++; a_run = s_b_valid ? a_run + 1 : 0; b_run = 0; end
            if (b_acc) begin tot_b++; b_run = s_a_valid ? b_run + 1 : 0; a_run = 0; end
            if (a_acc || b_acc) begin
                n_checks++; if (a_run > MAX_BURST || b_run > MAX_BURST) begin n_fails++; $display("FAIL rand_fairness: got run a=%0d b=%0d want <= %0d", a_run, b_run, MAX_BURST); end
            end
            if (popped) begin
                bit ok;
                if (out_src_log[$] == 1'b0) begin
                    ok = exp_a_q.size() > 0; exp_w = ok ? exp_a_q.pop_front() : '0;
                end else begin
                    ok = exp_b_q.size() > 0; exp_w = ok ? exp_b_q.pop_front() : '0;
                end
                n_checks++;
                if (!ok || out_data_log[$] !== exp_w) begin
                    n_fails++; $display("FAIL rand_word: got src=%b %h want %h (queued=%0d)", out_src_log[$], out_data_log[$], exp_w, ok);
                end
            end
            if (drain && a_src_q.size() == 0 && b_src_q.size() == 0 && exp_a_q.size() == 0 && exp_b_q.size() == 0 && !s_out_valid) break;
        end
        n_checks++;
        if (a_src_q.size() + b_src_q.size() + exp_a_q.size() + exp_b_q.size() != 0) begin
            n_fails++; $display("FAIL rand_drain: got %0d words outstanding want 0", a_src_q.size() + b_src_q.size() + exp_a_q.size() + exp_b_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
        a_data = '0; b_data = '0;
        test_reset();
        test_single_source();
        test_contention();
        test_backpressure();
        test_saturation_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
